// File: rtl/jtag_gpio_pkg.sv
// Shared register-select and op encodings for the JTAG GPIO bank, plus the
// per-bit write/set/clear merge used on Update-DR.
package jtag_gpio_pkg;

   localparam logic [1:0] REG_OE   = 2'd0;
   localparam logic [1:0] REG_OUT  = 2'd1;
   localparam logic [1:0] REG_IN   = 2'd2;
   localparam logic [1:0] REG_EDGE = 2'd3;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLR   = 2'b11;

   function automatic logic merge_bit(input logic [1:0] op, input logic cur, input logic d);
      case (op)
         OP_WRITE: merge_bit = d;
         OP_SET:   merge_bit = cur | d;
         OP_CLR:   merge_bit = cur & ~d;
         default:  merge_bit = cur;
      endcase
   endfunction

endpackage

// File: rtl/jtag_gpio_in_sync.sv
// Pad input synchroniser with sticky change flags. Edge detection stays
// disarmed until the sync chain and prev register hold real pad samples.
module jtag_gpio_in_sync
   import jtag_gpio_pkg::*;
#(
   parameter int NR_GPIOS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                i_tck,
   input  logic                i_reset_,
   input  logic [NR_GPIOS-1:0] i_gpio_inputs,
   input  logic [NR_GPIOS-1:0] i_clr_mask,
   output logic [NR_GPIOS-1:0] o_synced,
   output logic [NR_GPIOS-1:0] o_flags
);

   localparam int              CW    = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0]   PRIME = CW'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][NR_GPIOS-1:0] r_sync;
   logic [NR_GPIOS-1:0]                  r_prev;
   logic [NR_GPIOS-1:0]                  r_flags;
   logic [CW-1:0]                        r_prime;
   logic                                 w_armed;
   logic [NR_GPIOS-1:0]                  w_set;

   assign o_synced = r_sync[SYNC_STAGES-1];
   assign o_flags  = r_flags;
   assign w_armed  = (r_prime == PRIME);
   assign w_set    = w_armed ? (o_synced ^ r_prev) : '0;

   always_ff @(posedge i_tck or negedge i_reset_) begin
      if (!i_reset_) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_gpio_inputs};
         r_prev <= o_synced;
      end
   end

   // Saturates at PRIME; only then do sync and prev both carry pad data.
   always_ff @(posedge i_tck or negedge i_reset_) begin
      if (!i_reset_)
         r_prime <= '0;
      else if (!w_armed)
         r_prime <= r_prime + 1'b1;
   end

   // Set beats a simultaneous write-1-to-clear so no change is ever lost.
   always_ff @(posedge i_tck or negedge i_reset_) begin
      if (!i_reset_)
         r_flags <= '0;
      else
         r_flags <= (r_flags & ~i_clr_mask) | w_set;
   end

endmodule

// File: rtl/jtag_gpio_bank.sv
// JTAG GPIO bank: SCAN_N picks one of OE/OUT/IN/EDGE, EXTEST scans a
// {op, data} DR that reads the selected register and writes/sets/clears it.
module jtag_gpio_bank
   import jtag_gpio_pkg::*;
#(
   parameter int NR_GPIOS    = 8,
   parameter int SYNC_STAGES = 2,
   parameter bit OE_RESET    = 1'b0
) (
   input  logic                tck,
   input  logic                reset_,
   input  logic                tdi,
   output logic                gpios_tdo,
   input  logic                capture_dr,
   input  logic                shift_dr,
   input  logic                update_dr,
   input  logic                scan_n_ir,
   input  logic                extest_ir,
   input  logic [NR_GPIOS-1:0] gpio_inputs,
   output logic [NR_GPIOS-1:0] gpio_outputs,
   output logic [NR_GPIOS-1:0] gpio_outputs_ena
);

   localparam int DW = NR_GPIOS + 2;

   logic [1:0]          r_reg_sel;
   logic [DW-1:0]       r_dr;
   logic [NR_GPIOS-1:0] r_oe;
   logic [NR_GPIOS-1:0] r_out;

   logic                w_cap;
   logic                w_shf;
   logic                w_upd;
   logic [1:0]          w_op;
   logic [NR_GPIOS-1:0] w_d;
   logic [NR_GPIOS-1:0] w_synced;
   logic [NR_GPIOS-1:0] w_flags;
   logic [NR_GPIOS-1:0] w_sel_val;
   logic [NR_GPIOS-1:0] w_oe_nxt;
   logic [NR_GPIOS-1:0] w_out_nxt;
   logic [NR_GPIOS-1:0] w_clr;

   // Strobe priority: capture over shift over update.
   assign w_cap = extest_ir & capture_dr;
   assign w_shf = extest_ir & shift_dr & ~capture_dr;
   assign w_upd = extest_ir & update_dr & ~capture_dr & ~shift_dr;
   assign w_op  = r_dr[DW-1:DW-2];
   assign w_d   = r_dr[NR_GPIOS-1:0];

   assign gpio_outputs     = r_out;
   assign gpio_outputs_ena = r_oe;
   assign gpios_tdo        = scan_n_ir ? r_reg_sel[0] : r_dr[0];

   jtag_gpio_in_sync #(
      .NR_GPIOS    (NR_GPIOS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_in_sync (
      .i_tck         (tck),
      .i_reset_      (reset_),
      .i_gpio_inputs (gpio_inputs),
      .i_clr_mask    (w_clr),
      .o_synced      (w_synced),
      .o_flags       (w_flags)
   );

   always_comb begin
      case (r_reg_sel)
         REG_OE:   w_sel_val = r_oe;
         REG_OUT:  w_sel_val = r_out;
         REG_IN:   w_sel_val = w_synced;
         default:  w_sel_val = w_flags;
      endcase
   end

   // IN ignores every op; EDGE treats any non-zero op as write-1-to-clear.
   always_comb begin
      w_oe_nxt  = r_oe;
      w_out_nxt = r_out;
      w_clr     = '0;
      if (w_upd) begin
         case (r_reg_sel)
            REG_OE:
               for (int i = 0; i < NR_GPIOS; i++)
                  w_oe_nxt[i] = merge_bit(w_op, r_oe[i], w_d[i]);
            REG_OUT:
               for (int i = 0; i < NR_GPIOS; i++)
                  w_out_nxt[i] = merge_bit(w_op, r_out[i], w_d[i]);
            REG_EDGE:
               if (w_op != OP_NONE)
                  w_clr = w_d;
            default: ;
         endcase
      end
   end

   // reg_sel shifts LSB first and survives instruction changes.
   always_ff @(posedge tck or negedge reset_) begin
      if (!reset_)
         r_reg_sel <= '0;
      else if (scan_n_ir && shift_dr)
         r_reg_sel <= {tdi, r_reg_sel[1]};
   end

   always_ff @(posedge tck or negedge reset_) begin
      if (!reset_)
         r_dr <= '0;
      else if (w_cap)
         r_dr <= {2'b00, w_sel_val};
      else if (w_shf)
         r_dr <= {tdi, r_dr[DW-1:1]};
   end

   always_ff @(posedge tck or negedge reset_) begin
      if (!reset_) begin
         r_oe  <= {NR_GPIOS{OE_RESET}};
         r_out <= '0;
      end else begin
         r_oe  <= w_oe_nxt;
         r_out <= w_out_nxt;
      end
   end

endmodule

// File: tb/tb_jtag_gpio_bank.sv
// Self-checking bench for jtag_gpio_bank: table-driven OE/OUT scans plus
// hand-written input, edge-flag, and reset sequences; captures go through a queue.
module tb_jtag_gpio_bank;
   import jtag_gpio_pkg::*;

   localparam int N = 8;

   logic         tck = 1'b0;
   logic         reset_ = 1'b0;
   logic         tdi = 1'b0;
   logic         capture_dr = 1'b0;
   logic         shift_dr = 1'b0;
   logic         update_dr = 1'b0;
   logic         scan_n_ir = 1'b0;
   logic         extest_ir = 1'b0;
   logic [N-1:0] gpio_inputs = '0;
   logic         gpios_tdo;
   logic [N-1:0] gpio_outputs;
   logic [N-1:0] gpio_outputs_ena;

   int checks = 0;
   int failures = 0;
   logic [N+1:0] sb_q[$];

   typedef struct {
      logic [1:0]   sel;
      logic [1:0]   op;
      logic [N-1:0] data;
      logic [N-1:0] cap;
      logic [N-1:0] oe;
      logic [N-1:0] out;
   } vec_t;
   vec_t tbl[8];

   jtag_gpio_bank #(.NR_GPIOS(N), .SYNC_STAGES(2), .OE_RESET(1'b0)) dut (
      .tck              (tck),
      .reset_           (reset_),
      .tdi              (tdi),
      .gpios_tdo        (gpios_tdo),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .scan_n_ir        (scan_n_ir),
      .extest_ir        (extest_ir),
      .gpio_inputs      (gpio_inputs),
      .gpio_outputs     (gpio_outputs),
      .gpio_outputs_ena (gpio_outputs_ena)
   );

   always #5 tck = ~tck;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic select_reg(input logic [1:0] sel);
      @(negedge tck); scan_n_ir = 1'b1; shift_dr = 1'b1; tdi = sel[0];
      @(negedge tck); tdi = sel[1];
      @(negedge tck); shift_dr = 1'b0; scan_n_ir = 1'b0; tdi = 1'b0;
   endtask

   // Capture, shift {op,data} in LSB first while collecting tdo, then update.
   // tog is XORed onto the pads so its synced change lands on the update edge.
   task automatic scan(input logic [1:0] op, input logic [N-1:0] data,
                       input logic [N-1:0] tog, output logic [N+1:0] cap);
      logic [N+1:0] sh;
      sh = {op, data};
      @(negedge tck); extest_ir = 1'b1; capture_dr = 1'b1;
      for (int i = 0; i < N + 2; i++) begin
         @(negedge tck); capture_dr = 1'b0; shift_dr = 1'b1; tdi = sh[i];
         if (i == N) gpio_inputs = gpio_inputs ^ tog;
         cap[i] = gpios_tdo;
      end
      @(negedge tck); shift_dr = 1'b0; update_dr = 1'b1; tdi = 1'b0;
      @(negedge tck); update_dr = 1'b0; extest_ir = 1'b0;
   endtask

   task automatic scan_chk(input string name, input logic [1:0] op, input logic [N-1:0] data,
                           input logic [N-1:0] tog, input logic [N+1:0] exp_cap);
      logic [N+1:0] cap;
      sb_q.push_back(exp_cap);
      scan(op, data, tog, cap);
      check(name, cap, sb_q.pop_front());
   endtask

   initial begin
      tbl[0] = '{REG_OE,  OP_WRITE, 8'hA5, 8'h00, 8'hA5, 8'h00};
      tbl[1] = '{REG_OE,  OP_NONE,  8'h00, 8'hA5, 8'hA5, 8'h00};
      tbl[2] = '{REG_OUT, OP_WRITE, 8'h0F, 8'h00, 8'hA5, 8'h0F};
      tbl[3] = '{REG_OUT, OP_SET,   8'hF0, 8'h0F, 8'hA5, 8'hFF};
      tbl[4] = '{REG_OUT, OP_CLR,   8'h3C, 8'hFF, 8'hA5, 8'hC3};
      tbl[5] = '{REG_OUT, OP_NONE,  8'h00, 8'hC3, 8'hA5, 8'hC3};
      tbl[6] = '{REG_OE,  OP_CLR,   8'h05, 8'hA5, 8'hA0, 8'hC3};
      tbl[7] = '{REG_OE,  OP_SET,   8'h0F, 8'hA0, 8'hAF, 8'hC3};

      repeat (2) @(negedge tck);
      check("rst_oe", gpio_outputs_ena, 8'h00);
      check("rst_out", gpio_outputs, 8'h00);
      check("rst_tdo", gpios_tdo, 1'b0);
      reset_ = 1'b1;

      for (int k = 0; k < 8; k++) begin
         select_reg(tbl[k].sel);
         scan_chk($sformatf("tbl%0d_cap", k), tbl[k].op, tbl[k].data, '0, {2'b00, tbl[k].cap});
         check($sformatf("tbl%0d_oe", k), gpio_outputs_ena, tbl[k].oe);
         check($sformatf("tbl%0d_out", k), gpio_outputs, tbl[k].out);
      end

      // Synced input readback; writes to IN are ignored.
      gpio_inputs = 8'h81;
      repeat (4) @(negedge tck);
      select_reg(REG_IN);
      scan_chk("in_cap", OP_WRITE, 8'h33, '0, {2'b00, 8'h81});
      check("in_wr_oe", gpio_outputs_ena, 8'hAF);
      check("in_wr_out", gpio_outputs, 8'hC3);

      // Edge flags: the 0->0x81 change is flagged, then cleared and reused.
      select_reg(REG_EDGE);
      scan_chk("edge_init", OP_WRITE, 8'hFF, '0, {2'b00, 8'h81});
      scan_chk("edge_cleared", OP_NONE, 8'h00, '0, {2'b00, 8'h00});
      gpio_inputs = 8'h89;
      repeat (4) @(negedge tck);
      scan_chk("edge_b3", OP_NONE, 8'h00, '0, {2'b00, 8'h08});
      scan_chk("edge_w1c", OP_CLR, 8'h08, '0, {2'b00, 8'h08});
      scan_chk("edge_after_w1c", OP_NONE, 8'h00, '0, {2'b00, 8'h00});
      scan_chk("edge_coinc", OP_CLR, 8'h08, 8'h08, {2'b00, 8'h00});
      scan_chk("edge_set_wins", OP_NONE, 8'h00, '0, {2'b00, 8'h08});

      // Async reset mid-shift, then an update with no op bits shifted in.
      select_reg(REG_OUT);
      scan_chk("pre_rst_cap", OP_WRITE, 8'h55, '0, {2'b00, 8'hC3});
      check("pre_rst_out", gpio_outputs, 8'h55);
      @(negedge tck); scan_n_ir = 1'b1; extest_ir = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
      repeat (3) @(negedge tck);
      #2 reset_ = 1'b0;
      #1;
      check("async_out", gpio_outputs, 8'h00);
      check("async_oe", gpio_outputs_ena, 8'h00);
      check("async_regsel", gpios_tdo, 1'b0);
      @(negedge tck); reset_ = 1'b1; shift_dr = 1'b0; scan_n_ir = 1'b0; tdi = 1'b0;
      @(negedge tck); update_dr = 1'b1;
      @(negedge tck); update_dr = 1'b0; extest_ir = 1'b0;
      check("post_rst_upd_out", gpio_outputs, 8'h00);
      check("post_rst_upd_oe", gpio_outputs_ena, 8'h00);

      // Pads high across reset release must not raise flags while priming.
      gpio_inputs = 8'hFF;
      @(negedge tck); reset_ = 1'b0;
      repeat (2) @(negedge tck);
      reset_ = 1'b1;
      repeat (6) @(negedge tck);
      select_reg(REG_EDGE);
      scan_chk("edge_prime", OP_NONE, 8'h00, '0, {2'b00, 8'h00});
      select_reg(REG_IN);
      scan_chk("in_after_prime", OP_NONE, 8'h00, '0, {2'b00, 8'hFF});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jtag_gpio_bank.md
Name: jtag_gpio_bank

Overview:
Second-generation JTAG-controlled GPIO bank, driven by the real or virtual TAP over the EXTEST and SCAN_N instructions.
- Generalises the single config/data pair to four addressable registers: output-enable, output, synchronised input, and sticky input-change flags.
- Adds per-bit set and clear write operations, so host read-modify-write is not needed.
- Sits beside the TAP; its TDO is muxed into the TAP's DR path.

Parameters:
- NR_GPIOS, 8, number of GPIO pins (1..64).
- SYNC_STAGES, 2, input synchroniser depth in tck flops (2..4).
- OE_RESET, 0, reset value of every gpio_outputs_ena bit (0 or 1).

Ports:
- tck  in  1  TAP clock; all state on rising edge.
- reset_  in  1  asynchronous active-low reset.
- tdi  in  1  scan data in.
- gpios_tdo  out  1  scan data out.
- capture_dr  in  1  TAP in Capture-DR.
- shift_dr  in  1  TAP in Shift-DR.
- update_dr  in  1  TAP in Update-DR.
- scan_n_ir  in  1  SCAN_N instruction active.
- extest_ir  in  1  EXTEST instruction active.
- gpio_inputs  in  NR_GPIOS  asynchronous pad inputs.
- gpio_outputs  out  NR_GPIOS  pad output values (registered).
- gpio_outputs_ena  out  NR_GPIOS  pad output enables (registered).

Behaviour:
- Reset (async assert, release synchronous to tck), all zero except gpio_outputs_ena:
  - gpio_outputs = 0.
  - gpio_outputs_ena = {NR_GPIOS{OE_RESET}}.
  - reg_sel = 0, dr = 0, sync flops = 0, edge flags = 0, prev = 0, prime counter = 0.
  - Reset mid-scan aborts the scan; no partial update is applied.
- Register select (SCAN_N):
  - 2-bit reg_sel; while scan_n_ir && shift_dr: reg_sel <= {tdi, reg_sel[1]} (LSB first).
  - Encoding: 0 = OE, 1 = OUT, 2 = IN, 3 = EDGE.
  - reg_sel holds its value across instruction changes.
- DR chain: dr is NR_GPIOS+2 bits; bits [NR_GPIOS+1:NR_GPIOS] are the op field.
  - All DR actions below are qualified by extest_ir.
  - If several TAP strobes are high, priority is capture > shift > update.
- capture_dr: dr <= {2'b00, selected register}. Selected register is gpio_outputs_ena, gpio_outputs, synced inputs, or edge flags, per reg_sel.
- shift_dr: dr <= {tdi, dr[NR_GPIOS+1:1]}.
- update_dr: apply op with D = dr[NR_GPIOS-1:0]. Target register changes on the same tck edge that samples update_dr.
  - Op 00: no write (read-only scan).
  - Op 01: OE/OUT <= D.
  - Op 10: OE/OUT <= reg | D (set).
  - Op 11: OE/OUT <= reg & ~D (clear).
  - IN: any op is ignored.
  - EDGE: any op ≠ 00 clears the flags where D = 1 (write-1-to-clear).
- gpios_tdo:
  - reg_sel[0] when scan_n_ir.
  - Otherwise dr[0].
  - Combinational.
- Input path: SYNC_STAGES-deep synchroniser per bit; prev holds the last synced value.
  - Edge detect is armed only after the prime counter reaches SYNC_STAGES+1 tck cycles after reset. No spurious flags from reset values.
  - Once armed: flag[i] sets when synced[i] ≠ prev[i].
  - A set in the same cycle as a clear: set wins.
  - Flags are sticky until cleared.
- Input sampling advances only while tck toggles. Changes shorter than SYNC_STAGES tck periods may be missed.

Decomposition:
- Package jtag_gpio_pkg:
  - Register select localparams: REG_OE = 2'd0, REG_OUT = 2'd1, REG_IN = 2'd2, REG_EDGE = 2'd3.
  - Op codes: OP_NONE = 2'b00, OP_WRITE = 2'b01, OP_SET = 2'b10, OP_CLR = 2'b11.
  - A function for the set/clear/write merge.
- Sub-module jtag_gpio_in_sync contains:
  - synchroniser, prev register and prime counter;
  - edge-flag storage with set-priority clear port;
  - outputs: synced value and flags.

Test Plan (NR_GPIOS = 8, SYNC_STAGES = 2, OE_RESET = 0):
1. Reset, then select OE; scan {01, 0xA5}; update → gpio_outputs_ena = 0xA5. Rescan with op 00 → captured 0xA5 shifted out, ena unchanged.
2. OUT = 0x0F via op 01; then op 10 with 0xF0 → 0xFF; then op 11 with 0x3C → 0xC3.
3. gpio_inputs = 0x81 held ≥ 3 tck, select IN, capture → tdo stream yields 0x81 then 00. An update with op 01 leaves outputs unchanged.
4. Toggle gpio_inputs bit 3 after arming → EDGE capture = 0x08. W1C with 0x08 → 0x00. An edge coinciding with the W1C update cycle leaves the flag set.
5. Inputs = 0xFF during reset release → no flag set during or after priming (EDGE reads 0x00).
6. Assert reset_ mid-shift with OUT previously 0x55 → gpio_outputs = 0, ena = 0, reg_sel = 0 immediately (asynchronous). Subsequent update_dr with op bits not shifted in causes no write.
